// File: rtl/mem_access_unit_if.sv
// Handshake bundle for the memory stage: request from execute, response to
// writeback, and the data-memory bus. slave = the unit, master = its environment.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_memr;
  logic        req_memw;
  logic [2:0]  req_memt;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_wreg;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_wback;
  logic [4:0]  resp_wreg;
  logic [31:0] resp_wdata;
  logic        resp_fault;

  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;

  logic        fb_hit;

  modport slave (
    input  req_valid, req_memr, req_memw, req_memt, req_addr, req_wdata, req_wreg,
    output req_ready,
    output resp_valid, resp_wback, resp_wreg, resp_wdata, resp_fault,
    input  resp_ready,
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rdata, bus_rvalid,
    output fb_hit
  );

  modport master (
    output req_valid, req_memr, req_memw, req_memt, req_addr, req_wdata, req_wreg,
    input  req_ready,
    input  resp_valid, resp_wback, resp_wreg, resp_wdata, resp_fault,
    output resp_ready,
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rdata, bus_rvalid,
    input  fb_hit
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: one data-memory access per request, load extension, fault
// detection for illegal/misaligned/timed-out accesses, framebuffer tagging.
//
// state | meaning
// IDLE  | ready for a request; latches it on req_valid
// ISSUE | bus_valid held with stable fields until bus_ready
// WAIT  | load issued; waiting for bus_rvalid or timeout
// RESP  | response held until resp_ready
module mem_access_unit #(
  parameter logic [31:0] FB_BASE      = 32'h0100_0000,
  parameter int          FB_SIZE_LOG2 = 20,
  parameter int          TIMEOUT      = 255
) (
  input logic         clk,
  input logic         rst_n,
  mem_access_unit_if.slave mif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        r_memr, r_memw;
  logic [2:0]  r_memt;
  logic [31:0] r_addr, r_wdata;
  logic [4:0]  r_wreg;
  logic        r_fault;
  logic [31:0] r_data;
  logic [7:0]  tmr;

  logic        in_half, in_word, in_access, in_illegal, in_bubble;
  logic [31:0] lane, ext_data;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic        wback;

  always_comb begin
    in_half    = (mif.req_memt == 3'd1) || (mif.req_memt == 3'd4) || (mif.req_memt == 3'd6);
    in_word    = (mif.req_memt == 3'd2) || (mif.req_memt == 3'd7);
    in_access  = mif.req_memr || mif.req_memw;
    in_bubble  = !in_access;
    in_illegal = (mif.req_memr && mif.req_memw)
              || (mif.req_memr && (mif.req_memt >= 3'd5))
              || (mif.req_memw && (mif.req_memt <  3'd5))
              || (in_access && in_half && mif.req_addr[0])
              || (in_access && in_word && (mif.req_addr[1:0] != 2'b00));
  end

  always_comb begin
    lane = mif.bus_rdata >> {r_addr[1:0], 3'b000};
    case (r_memt)
      3'd0:    ext_data = {{24{lane[7]}}, lane[7:0]};
      3'd1:    ext_data = {{16{lane[15]}}, lane[15:0]};
      3'd3:    ext_data = {24'b0, lane[7:0]};
      3'd4:    ext_data = {16'b0, lane[15:0]};
      default: ext_data = mif.bus_rdata;
    endcase
  end

  // Replicate store data across lanes so the strobes alone pick the bytes.
  always_comb begin
    case (r_memt)
      3'd5: begin
        st_strb  = 4'b0001 << r_addr[1:0];
        st_wdata = {4{r_wdata[7:0]}};
      end
      3'd6: begin
        st_strb  = 4'b0011 << r_addr[1:0];
        st_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = r_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    wback           = 1'b0;
    mif.req_ready   = 1'b0;
    mif.bus_valid   = 1'b0;
    mif.bus_we      = 1'b0;
    mif.bus_addr    = '0;
    mif.bus_wdata   = '0;
    mif.bus_wstrb   = '0;
    mif.resp_valid  = 1'b0;
    mif.resp_wback  = 1'b0;
    mif.resp_wreg   = '0;
    mif.resp_wdata  = '0;
    mif.resp_fault  = 1'b0;
    mif.fb_hit      = 1'b0;
    case (state)
      IDLE: begin
        mif.req_ready = 1'b1;
        if (mif.req_valid) state_nxt = (in_illegal || in_bubble) ? RESP : ISSUE;
      end
      ISSUE: begin
        mif.bus_valid = 1'b1;
        mif.bus_we    = r_memw;
        mif.bus_addr  = {r_addr[31:2], 2'b00};
        mif.bus_wstrb = r_memw ? st_strb : 4'b0000;
        mif.bus_wdata = r_memw ? st_wdata : 32'h0;
        mif.fb_hit    = (r_addr[31:FB_SIZE_LOG2] == FB_BASE[31:FB_SIZE_LOG2]);
        if (mif.bus_ready) state_nxt = r_memw ? RESP : WAIT;
      end
      WAIT: begin
        if (mif.bus_rvalid || (tmr == 8'd0)) state_nxt = RESP;
      end
      RESP: begin
        wback           = !r_fault && r_memr && (r_wreg != 5'd0);
        mif.resp_valid  = 1'b1;
        mif.resp_wback  = wback;
        mif.resp_wreg   = r_wreg;
        mif.resp_wdata  = wback ? r_data : 32'h0;
        mif.resp_fault  = r_fault;
        if (mif.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Timeout is a down-counter: loaded at the load handshake, faults at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_memr  <= 1'b0;
      r_memw  <= 1'b0;
      r_memt  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wreg  <= '0;
      r_fault <= 1'b0;
      r_data  <= '0;
      tmr     <= '0;
    end else begin
      if (state == IDLE && mif.req_valid) begin
        r_memr  <= mif.req_memr;
        r_memw  <= mif.req_memw;
        r_memt  <= mif.req_memt;
        r_addr  <= mif.req_addr;
        r_wdata <= mif.req_wdata;
        r_wreg  <= mif.req_wreg;
        r_fault <= in_illegal;
        r_data  <= '0;
      end
      if (state == ISSUE && mif.bus_ready) tmr <= TMR_LOAD;
      if (state == WAIT) begin
        if (mif.bus_rvalid)     r_data  <= ext_data;
        else if (tmr == 8'd0)   r_fault <= 1'b1;
        else                    tmr     <= tmr - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table through a scoreboard, plus hand
// sequences for timeout, response back-pressure and reset during WAIT.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if mif();

  mem_access_unit #(
    .FB_BASE(32'h0100_0000),
    .FB_SIZE_LOG2(20),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mif(mif)
  );

  typedef struct {
    string       name;
    logic        memr, memw;
    logic [2:0]  memt;
    logic [31:0] addr, wdata;
    logic [4:0]  wreg;
    logic [31:0] rdata;
    bit          exp_bus;
    logic [3:0]  exp_strb;
    logic [31:0] exp_bwdata;
    logic        exp_fb;
    logic        exp_wback;
    logic [31:0] exp_rwdata;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  typedef struct {
    string       name;
    logic        wback;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        fault;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic memr, input logic memw,
                              input logic [2:0] memt, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] wreg,
                              input logic [31:0] rdata, input bit bus,
                              input logic [3:0] strb, input logic [31:0] bwdata,
                              input logic fb, input logic wback,
                              input logic [31:0] rwdata, input logic fault, input int lat);
    vec_t v;
    v.name = nm; v.memr = memr; v.memw = memw; v.memt = memt; v.addr = addr;
    v.wdata = wdata; v.wreg = wreg; v.rdata = rdata; v.exp_bus = bus;
    v.exp_strb = strb; v.exp_bwdata = bwdata; v.exp_fb = fb; v.exp_wback = wback;
    v.exp_rwdata = rwdata; v.exp_fault = fault; v.exp_lat = lat;
    return v;
  endfunction

  task automatic idle_inputs();
    mif.req_valid = 0; mif.req_memr = 0; mif.req_memw = 0; mif.req_memt = 0;
    mif.req_addr = 0; mif.req_wdata = 0; mif.req_wreg = 0; mif.resp_ready = 0;
    mif.bus_ready = 0; mif.bus_rdata = 0; mif.bus_rvalid = 0;
  endtask

  // Present a request at a negedge; returns on the negedge after acceptance.
  task automatic send_req(input vec_t v);
    exp_t e;
    @(negedge clk);
    chk({v.name, "/req_ready"}, mif.req_ready, 1);
    mif.req_memr = v.memr; mif.req_memw = v.memw; mif.req_memt = v.memt;
    mif.req_addr = v.addr; mif.req_wdata = v.wdata; mif.req_wreg = v.wreg;
    mif.req_valid = 1;
    @(negedge clk);
    mif.req_valid = 0;
    e.name = v.name; e.wback = v.exp_wback; e.wreg = v.wreg;
    e.wdata = v.exp_rwdata; e.fault = v.exp_fault;
    sb.push_back(e);
  endtask

  task automatic check_resp(input exp_t e);
    chk({e.name, "/resp_wback"}, mif.resp_wback, e.wback);
    chk({e.name, "/resp_wreg"},  mif.resp_wreg,  e.wreg);
    chk({e.name, "/resp_wdata"}, mif.resp_wdata, e.wdata);
    chk({e.name, "/resp_fault"}, mif.resp_fault, e.fault);
  endtask

  task automatic run_txn(input vec_t v);
    int cyc;
    bit done, saw_bus;
    exp_t e;
    send_req(v);
    cyc = 1; done = 0; saw_bus = 0;
    while (!done && cyc < 40) begin
      if (mif.bus_valid && !saw_bus) begin
        saw_bus = 1;
        chk({v.name, "/bus_addr"},  mif.bus_addr, {v.addr[31:2], 2'b00});
        chk({v.name, "/bus_we"},    mif.bus_we, v.memw);
        chk({v.name, "/bus_wstrb"}, mif.bus_wstrb, v.exp_strb);
        chk({v.name, "/fb_hit"},    mif.fb_hit, v.exp_fb);
        if (v.memw) chk({v.name, "/bus_wdata"}, mif.bus_wdata, v.exp_bwdata);
        mif.bus_ready = 1;
        @(negedge clk); cyc++;
        mif.bus_ready = 0;
        if (!v.memw) begin
          mif.bus_rdata = v.rdata; mif.bus_rvalid = 1;
          @(negedge clk); cyc++;
          mif.bus_rvalid = 0; mif.bus_rdata = 0;
        end
      end else if (mif.resp_valid) begin
        chk({v.name, "/latency"}, cyc, v.exp_lat);
        e = sb.pop_front();
        check_resp(e);
        mif.resp_ready = 1;
        @(negedge clk);
        mif.resp_ready = 0;
        done = 1;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s/timeout: got no resp_valid expected one within 40 cycles", v.name);
      void'(sb.pop_front());
    end
    chk({v.name, "/bus_used"}, saw_bus, v.exp_bus);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    exp_t e;
    vecs.push_back(mk("lb_103",   1,0,3'd0,32'h0000_0103,32'h0,5'd5,32'h80FF_1234,1,4'h0,32'h0,0,1,32'hFFFF_FF80,0,3));
    vecs.push_back(mk("ulb_103",  1,0,3'd3,32'h0000_0103,32'h0,5'd5,32'h80FF_1234,1,4'h0,32'h0,0,1,32'h0000_0080,0,3));
    vecs.push_back(mk("sh_fb",    0,1,3'd6,32'h0100_0002,32'h0000_ABCD,5'd4,32'h0,1,4'b1100,32'hABCD_ABCD,1,0,32'h0,0,2));
    vecs.push_back(mk("lw_misal", 1,0,3'd2,32'h0000_0006,32'h0,5'd6,32'h0,0,4'h0,32'h0,0,0,32'h0,1,1));
    vecs.push_back(mk("rw_both",  1,1,3'd2,32'h0000_0006,32'h0,5'd6,32'h0,0,4'h0,32'h0,0,0,32'h0,1,1));
    vecs.push_back(mk("rw_both8", 1,1,3'd2,32'h0000_0008,32'h0,5'd6,32'h0,0,4'h0,32'h0,0,0,32'h0,1,1));
    vecs.push_back(mk("lh_102",   1,0,3'd1,32'h0000_0102,32'h0,5'd3,32'h8001_7FFF,1,4'h0,32'h0,0,1,32'hFFFF_8001,0,3));
    vecs.push_back(mk("ulh_102",  1,0,3'd4,32'h0000_0102,32'h0,5'd3,32'h8001_7FFF,1,4'h0,32'h0,0,1,32'h0000_8001,0,3));
    vecs.push_back(mk("sb_201",   0,1,3'd5,32'h0000_0201,32'h1234_56A5,5'd2,32'h0,1,4'b0010,32'hA5A5_A5A5,0,0,32'h0,0,2));
    vecs.push_back(mk("sw_fb",    0,1,3'd7,32'h0100_0010,32'hDEAD_BEEF,5'd2,32'h0,1,4'b1111,32'hDEAD_BEEF,1,0,32'h0,0,2));
    vecs.push_back(mk("lb_r0",    1,0,3'd0,32'h0000_0000,32'h0,5'd0,32'h0000_007F,1,4'h0,32'h0,0,0,32'h0,0,3));
    vecs.push_back(mk("bubble",   0,0,3'd2,32'h0000_0000,32'h0,5'd8,32'h0,0,4'h0,32'h0,0,0,32'h0,0,1));
    vecs.push_back(mk("r_sttype", 1,0,3'd5,32'h0000_0000,32'h0,5'd8,32'h0,0,4'h0,32'h0,0,0,32'h0,1,1));
    vecs.push_back(mk("w_ldtype", 0,1,3'd2,32'h0000_0000,32'h0,5'd8,32'h0,0,4'h0,32'h0,0,0,32'h0,1,1));
    vecs.push_back(mk("lh_odd",   1,0,3'd1,32'h0000_0001,32'h0,5'd8,32'h0,0,4'h0,32'h0,0,0,32'h0,1,1));
    vecs.push_back(mk("sh_odd",   0,1,3'd6,32'h0000_0003,32'h0,5'd8,32'h0,0,4'h0,32'h0,0,0,32'h0,1,1));
    vecs.push_back(mk("lw_blwfb", 1,0,3'd2,32'h00FF_FFFC,32'h0,5'd10,32'hCAFE_F00D,1,4'h0,32'h0,0,1,32'hCAFE_F00D,0,3));
    vecs.push_back(mk("lw_fbtop", 1,0,3'd2,32'h010F_FFFC,32'h0,5'd10,32'h1357_9BDF,1,4'h0,32'h0,1,1,32'h1357_9BDF,0,3));
    vecs.push_back(mk("lw_abvfb", 1,0,3'd2,32'h0110_0000,32'h0,5'd10,32'h2468_ACE0,1,4'h0,32'h0,0,1,32'h2468_ACE0,0,3));
    vecs.push_back(mk("lb_lane2", 1,0,3'd0,32'h0000_0002,32'h0,5'd11,32'h0080_0000,1,4'h0,32'h0,0,1,32'hFFFF_FF80,0,3));
    vecs.push_back(mk("sb_lane3", 0,1,3'd5,32'h0000_0003,32'h0000_005A,5'd1,32'h0,1,4'b1000,32'h5A5A_5A5A,0,0,32'h0,0,2));
    vecs.push_back(mk("sh_lane0", 0,1,3'd6,32'h0000_0010,32'hFFFF_1234,5'd1,32'h0,1,4'b0011,32'h1234_1234,0,0,32'h0,0,2));

    idle_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst/req_ready",  mif.req_ready, 1);
    chk("rst/resp_valid", mif.resp_valid, 0);
    chk("rst/bus_valid",  mif.bus_valid, 0);
    chk("rst/resp_wdata", mif.resp_wdata, 0);
    chk("rst/fb_hit",     mif.fb_hit, 0);
    rst_n = 1;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Timeout: rvalid withheld, fault lands exactly 4 cycles after WAIT entry.
    v = mk("timeout", 1,0,3'd2,32'h0000_0040,32'h0,5'd7,32'h0,1,4'h0,32'h0,0,0,32'h0,1,0);
    send_req(v);
    chk("timeout/bus_valid", mif.bus_valid, 1);
    mif.bus_ready = 1;
    @(negedge clk);
    mif.bus_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("timeout/early_resp", mif.resp_valid, 0);
      @(negedge clk);
    end
    chk("timeout/resp_valid", mif.resp_valid, 1);
    e = sb.pop_front();
    check_resp(e);
    mif.bus_rdata = 32'hFFFF_FFFF; mif.bus_rvalid = 1;
    @(negedge clk);
    mif.bus_rvalid = 0; mif.bus_rdata = 0;
    chk("late_rvalid/resp_wdata", mif.resp_wdata, 0);
    chk("late_rvalid/resp_fault", mif.resp_fault, 1);
    mif.resp_ready = 1;
    @(negedge clk);
    mif.resp_ready = 0;
    chk("timeout/back_idle", mif.req_ready, 1);
    mif.bus_rvalid = 1; mif.bus_rdata = 32'h1111_1111;
    @(negedge clk);
    mif.bus_rvalid = 0; mif.bus_rdata = 0;
    chk("idle_rvalid/resp_valid", mif.resp_valid, 0);
    chk("idle_rvalid/req_ready",  mif.req_ready, 1);

    // Back-pressure: resp_ready low for 5 cycles.
    v = mk("stall", 1,0,3'd1,32'h0000_0002,32'h0,5'd9,32'h8001_0000,1,4'h0,32'h0,0,1,32'hFFFF_8001,0,3);
    send_req(v);
    mif.bus_ready = 1;
    @(negedge clk);
    mif.bus_ready = 0; mif.bus_rdata = v.rdata; mif.bus_rvalid = 1;
    @(negedge clk);
    mif.bus_rvalid = 0; mif.bus_rdata = 0;
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      chk("stall/resp_valid", mif.resp_valid, 1);
      chk("stall/req_ready",  mif.req_ready, 0);
      check_resp(e);
      @(negedge clk);
    end
    mif.resp_ready = 1;
    @(negedge clk);
    mif.resp_ready = 0;
    chk("stall/resp_done", mif.resp_valid, 0);
    chk("stall/req_ready_after", mif.req_ready, 1);

    // Reset while waiting on load data: access abandoned, no response.
    @(negedge clk);
    mif.req_memr = 1; mif.req_memw = 0; mif.req_memt = 3'd2;
    mif.req_addr = 32'h0000_0080; mif.req_wreg = 5'd12; mif.req_valid = 1;
    @(negedge clk);
    mif.req_valid = 0; mif.bus_ready = 1;
    @(negedge clk);
    mif.bus_ready = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("rstwait/req_ready",  mif.req_ready, 1);
    chk("rstwait/resp_valid", mif.resp_valid, 0);
    chk("rstwait/bus_valid",  mif.bus_valid, 0);
    chk("rstwait/bus_addr",   mif.bus_addr, 0);
    chk("rstwait/resp_wreg",  mif.resp_wreg, 0);
    for (int i = 0; i < 6; i++) begin
      chk("rstwait/no_resp", mif.resp_valid, 0);
      @(negedge clk);
    end
    run_txn(mk("lw_after_rst", 1,0,3'd2,32'h0000_0000,32'h0,5'd1,32'h1234_5678,1,4'h0,32'h0,0,1,32'h1234_5678,0,3));

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
